// File: rtl/mips_pkg.sv
// Shared fetch-stage constants and the program-counter FSM state type.
package mips_pkg;

  localparam int unsigned ANCHO    = 32;
  localparam int unsigned PASO     = 4;
  localparam int unsigned ANCHO_J  = 26;
  localparam logic [ANCHO-1:0] PC_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    BUSCA   = 2'd1,
    ENTREGA = 2'd2
  } estado_e;

endpackage

// File: rtl/calculo_destino.sv
// Redirect target: branch (pcRama + word offset) or jump (region bits + field).
module calculo_destino
  import mips_pkg::*;
(
  input  logic               fuentePc,
  input  logic [ANCHO-1:0]   pcRama,
  input  logic [ANCHO-1:0]   inmExt,
  input  logic [ANCHO_J-1:0] destinoJ,
  output logic [ANCHO-1:0]   destino_c
);

  logic [ANCHO-1:0] rama_c;
  logic [ANCHO-1:0] salto_c;

  // Branch wins over jump; the target is always word aligned.
  always_comb begin
    rama_c         = pcRama + (inmExt << 2);
    salto_c        = {pcRama[ANCHO-1:ANCHO-4], destinoJ, 2'b00};
    destino_c      = fuentePc ? rama_c : salto_c;
    destino_c[1:0] = 2'b00;
  end

endmodule

// File: rtl/contador_pc.sv
// Fetch-stage PC unit: holds the PC, fetches over req/ack and hands
// instructions to decode over valid/ready, honouring branch/jump redirects.
module contador_pc
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic               imemReq,
  output logic [ANCHO-1:0]   imemAddr,
  input  logic               imemAck,
  input  logic [ANCHO-1:0]   imemDato,
  output logic [ANCHO-1:0]   instr,
  output logic [ANCHO-1:0]   pcMas4,
  output logic               instrValida,
  input  logic               decodListo,
  input  logic               fuentePc,
  input  logic               saltoIncond,
  input  logic [ANCHO-1:0]   pcRama,
  input  logic [ANCHO-1:0]   inmExt,
  input  logic [ANCHO_J-1:0] destinoJ
);

  estado_e          estado_q, estado_d;
  logic [ANCHO-1:0] pc_q, pc_d;
  logic [ANCHO-1:0] addr_q, addr_d;
  logic [ANCHO-1:0] instr_q, instr_d;
  logic [ANCHO-1:0] pcmas4_q, pcmas4_d;
  logic             descarta_q, descarta_d;

  logic             redir_c;
  logic [ANCHO-1:0] destino_c;
  logic [ANCHO-1:0] pc_sig_c;

  calculo_destino u_destino (
    .fuentePc  (fuentePc),
    .pcRama    (pcRama),
    .inmExt    (inmExt),
    .destinoJ  (destinoJ),
    .destino_c (destino_c)
  );

  assign redir_c  = fuentePc | saltoIncond;
  assign pc_sig_c = pc_q + ANCHO'(PASO);

  assign imemReq  = (estado_q == BUSCA);
  assign imemAddr = addr_q;
  assign instr    = instr_q;
  assign pcMas4   = pcmas4_q;

  // Next-state and datapath; a request address only changes when a new
  // request starts, so a redirect never disturbs one already in flight.
  always_comb begin
    estado_d    = estado_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    pcmas4_d    = pcmas4_q;
    descarta_d  = descarta_q;
    instrValida = 1'b0;

    case (estado_q)
      ESPERA: begin
        if (redir_c) pc_d = destino_c;
        estado_d = BUSCA;
      end
      BUSCA: begin
        if (imemAck) begin
          descarta_d = 1'b0;
          if (!descarta_q && !redir_c) begin
            instr_d  = imemDato;
            pcmas4_d = pc_sig_c;
            estado_d = ENTREGA;
          end else if (redir_c) begin
            pc_d = destino_c;
          end
        end else if (redir_c) begin
          pc_d       = destino_c;
          descarta_d = 1'b1;
        end
      end
      ENTREGA: begin
        instrValida = !redir_c;
        if (redir_c) begin
          pc_d     = destino_c;
          estado_d = BUSCA;
        end else if (decodListo) begin
          pc_d     = pc_sig_c;
          estado_d = BUSCA;
        end
      end
      default: estado_d = ESPERA;
    endcase

    if ((estado_d == BUSCA) && ((estado_q != BUSCA) || imemAck)) addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= ESPERA;
      pc_q       <= PC_RESET;
      addr_q     <= PC_RESET;
      instr_q    <= '0;
      pcmas4_q   <= PC_RESET + ANCHO'(PASO);
      descarta_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      pcmas4_q   <= pcmas4_d;
      descarta_q <= descarta_d;
    end
  end

endmodule

// File: tb/tb_contador_pc.sv
// Directed bench for contador_pc: memory model plus queue-based scoreboard
// for acknowledged fetch addresses and instructions accepted by decode.
module tb_contador_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemDato;
  logic [31:0] instr;
  logic [31:0] pcMas4;
  logic        instrValida;
  logic        decodListo;
  logic        fuentePc;
  logic        saltoIncond;
  logic [31:0] pcRama;
  logic [31:0] inmExt;
  logic [25:0] destinoJ;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 0;
  logic        ack_forzado = 1'b0;

  logic [31:0] q_req[$];
  logic [63:0] q_xfer[$];

  contador_pc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemAck     (imemAck),
    .imemDato    (imemDato),
    .instr       (instr),
    .pcMas4      (pcMas4),
    .instrValida (instrValida),
    .decodListo  (decodListo),
    .fuentePc    (fuentePc),
    .saltoIncond (saltoIncond),
    .pcRama      (pcRama),
    .inmExt      (inmExt),
    .destinoJ    (destinoJ)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(imemReq && imemAddr == a) && n < 40) begin
      tick();
      n++;
    end
    check("wait_req_addr", imemAddr, a);
  endtask

  task automatic wait_entrega();
    int n = 0;
    while (!(instrValida && !imemReq) && n < 40) begin
      tick();
      n++;
    end
    check("wait_entrega", 32'(instrValida), 32'd1);
  endtask

  // Instruction memory: word at address a is {16'hC0DE, a[15:0]}, ack after lat idle req cycles.
  initial begin
    int cnt = 0;
    imemAck  = 1'b0;
    imemDato = '0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_forzado) begin
        imemAck  = 1'b1;
        imemDato = 32'hDEAD_BEEF;
        cnt      = 0;
      end else if (imemReq) begin
        if (cnt >= lat) begin
          imemAck  = 1'b1;
          imemDato = {16'hC0DE, imemAddr[15:0]};
          cnt      = 0;
        end else begin
          imemAck = 1'b0;
          cnt++;
        end
      end else begin
        imemAck = 1'b0;
        cnt     = 0;
      end
    end
  end

  // Monitor: checks every acknowledged request and every accepted instruction.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && imemReq && imemAck) begin
        if (q_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ack_unexpected: got addr %h expected no request", imemAddr);
        end else begin
          check("ack_addr", imemAddr, q_req.pop_front());
        end
      end
      if (rst_n && instrValida && decodListo) begin
        if (q_xfer.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got instr %h pcMas4 %h expected none", instr, pcMas4);
        end else begin
          e = q_xfer.pop_front();
          check("xfer_instr", instr, e[63:32]);
          check("xfer_pcMas4", pcMas4, e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    decodListo  = 1'b1;
    fuentePc    = 1'b0;
    saltoIncond = 1'b0;
    pcRama      = '0;
    inmExt      = '0;
    destinoJ    = '0;
    repeat (3) tick();

    // Reset values
    check("rst_imemReq", 32'(imemReq), 32'd0);
    check("rst_imemAddr", imemAddr, 32'h0);
    check("rst_instrValida", 32'(instrValida), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pcMas4", pcMas4, 32'h4);

    // Sequential fetch
    q_req.push_back(32'h0);  q_req.push_back(32'h4);  q_req.push_back(32'h8);
    q_req.push_back(32'hC);  q_req.push_back(32'h10);
    q_xfer.push_back({32'hC0DE_0000, 32'h4});
    q_xfer.push_back({32'hC0DE_0004, 32'h8});
    q_xfer.push_back({32'hC0DE_0008, 32'hC});
    q_xfer.push_back({32'hC0DE_000C, 32'h10});
    rst_n = 1'b1;
    check("espera_no_req", 32'(imemReq), 32'd0);
    tick();
    check("first_req", 32'(imemReq), 32'd1);
    check("first_addr", imemAddr, 32'h0);

    // Backpressure at 0x10
    wait_req(32'h10);
    decodListo = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(instrValida), 32'd1);
      check("hold_instr", instr, 32'hC0DE_0010);
      check("hold_pcMas4", pcMas4, 32'h14);
      check("hold_no_req", 32'(imemReq), 32'd0);
      tick();
    end
    q_xfer.push_back({32'hC0DE_0010, 32'h14});
    q_req.push_back(32'h14);
    decodListo = 1'b1;
    tick();
    check("after_hold_addr", imemAddr, 32'h14);

    // Branch taken in ENTREGA (negative offset)
    wait_entrega();
    fuentePc = 1'b1;
    pcRama   = 32'h24;
    inmExt   = 32'hFFFF_FFFE;
    #1;
    check("redir_no_valid", 32'(instrValida), 32'd0);
    tick();
    fuentePc = 1'b0;
    q_req.push_back(32'h1C);
    q_xfer.push_back({32'hC0DE_001C, 32'h20});
    q_req.push_back(32'h20);
    check("branch_req", 32'(imemReq), 32'd1);
    check("branch_addr", imemAddr, 32'h1C);

    // Branch to 0x40, then jump while the 0x40 request is in flight
    wait_req(32'h20);
    wait_entrega();
    fuentePc = 1'b1;
    pcRama   = 32'h24;
    inmExt   = 32'h7;
    lat      = 3;
    tick();
    fuentePc = 1'b0;
    q_req.push_back(32'h40);
    q_req.push_back(32'h400);
    q_xfer.push_back({32'hC0DE_0400, 32'h404});
    q_req.push_back(32'h404);
    check("busca40_addr", imemAddr, 32'h40);
    saltoIncond = 1'b1;
    pcRama      = 32'h44;
    destinoJ    = 26'h100;
    tick();
    saltoIncond = 1'b0;
    check("inflight_addr_c2", imemAddr, 32'h40);
    tick();
    check("inflight_addr_c3", imemAddr, 32'h40);
    tick();
    check("inflight_addr_c4", imemAddr, 32'h40);
    tick();
    lat = 0;
    check("jump_req", 32'(imemReq), 32'd1);
    check("jump_addr", imemAddr, 32'h400);
    check("discard_no_valid", 32'(instrValida), 32'd0);

    // Jump to the top word, then wrap to 0
    wait_req(32'h404);
    wait_entrega();
    saltoIncond = 1'b1;
    pcRama      = 32'hF000_0000;
    destinoJ    = 26'h3FF_FFFF;
    tick();
    saltoIncond = 1'b0;
    q_req.push_back(32'hFFFF_FFFC);
    q_xfer.push_back({32'hC0DE_FFFC, 32'h0});
    check("top_addr", imemAddr, 32'hFFFF_FFFC);
    wait_entrega();
    lat = 5;
    tick();
    check("wrap_req", 32'(imemReq), 32'd1);
    check("wrap_addr", imemAddr, 32'h0);

    // Asynchronous reset in BUSCA with an ack arriving during reset
    tick();
    rst_n       = 1'b0;
    ack_forzado = 1'b1;
    #1;
    check("arst_req", 32'(imemReq), 32'd0);
    check("arst_valid", 32'(instrValida), 32'd0);
    check("arst_addr", imemAddr, 32'h0);
    check("arst_instr", instr, 32'h0);
    repeat (2) tick();
    ack_forzado = 1'b0;
    lat         = 0;
    tick();
    q_req.push_back(32'h0);
    q_xfer.push_back({32'hC0DE_0000, 32'h4});
    q_req.push_back(32'h4);
    rst_n = 1'b1;
    check("rel_no_req", 32'(imemReq), 32'd0);
    check("rel_no_valid", 32'(instrValida), 32'd0);
    tick();
    check("rel_req", 32'(imemReq), 32'd1);
    check("rel_addr", imemAddr, 32'h0);
    wait_req(32'h4);
    decodListo = 1'b0;
    repeat (3) tick();

    check("req_queue_empty", 32'(q_req.size()), 32'd0);
    check("xfer_queue_empty", 32'(q_xfer.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
